// File: rtl/demux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// demux_scan_ctrl
//   Upstream driver for a 1-to-4 demux stage. A 4-bit word is accepted over a
//   valid/ready handshake and then serialized onto the demux controls: the
//   select index {s1,s0} steps 0..3, i carries word[index], and e stays high
//   for the whole transfer. Each select value is held HOLD_CYCLES clocks.
//   A one-cycle done pulse follows the last select slot.
//
//   Optional feature: define DEMUX_SCAN_CTRL_ABORT_EN to add the abort input,
//   which cancels a transfer in progress (no done pulse).
//
// Parameters:
//   HOLD_CYCLES  clocks each select value is held (1..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_data   word to distribute; bit n goes to demux output dn
//   in_valid  in_data valid
//   abort     (optional) cancel the current transfer
//   in_ready  block can accept a word
//   s0, s1    demux select LSB / MSB
//   i         demux data input
//   e         demux enable
//   busy      transfer in progress
//   done      one-cycle pulse when a transfer completes
//
//   All outputs are registered, so select, data and enable only move on
//   clock edges.
// -----------------------------------------------------------------------------
module demux_scan_ctrl #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
`ifdef DEMUX_SCAN_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       in_ready,
  output logic       s0,
  output logic       s1,
  output logic       i,
  output logic       e,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] word_reg, word_next;
  logic [1:0] index_reg, index_next;
  logic [7:0] hold_reg, hold_next;
  logic [1:0] sel_reg, sel_next;
  logic       i_reg, i_next;
  logic       e_reg, e_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       ready_reg, ready_next;

  logic       abort_hit;
  logic [1:0] index_inc;

`ifdef DEMUX_SCAN_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign index_inc = index_reg + 2'd1;

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    index_next = index_reg;
    hold_next  = hold_reg;
    sel_next   = sel_reg;
    i_next     = i_reg;
    e_next     = e_reg;
    busy_next  = busy_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid && ready_reg) begin
          // Output registers load the index-0 values now so that slot 0
          // is visible in the very next cycle.
          state_next = SHIFT;
          word_next  = in_data;
          index_next = 2'd0;
          hold_next  = 8'd0;
          sel_next   = 2'd0;
          i_next     = in_data[0];
          e_next     = 1'b1;
          busy_next  = 1'b1;
          ready_next = 1'b0;
        end
      end

      SHIFT: begin
        if (abort_hit || (hold_reg == HOLD_LAST && index_reg == 2'd3)) begin
          state_next = IDLE;
          index_next = 2'd0;
          hold_next  = 8'd0;
          sel_next   = 2'd0;
          i_next     = 1'b0;
          e_next     = 1'b0;
          busy_next  = 1'b0;
          ready_next = 1'b1;
          done_next  = !abort_hit;
        end else if (hold_reg == HOLD_LAST) begin
          hold_next  = 8'd0;
          index_next = index_inc;
          sel_next   = index_inc;
          i_next     = word_reg[index_inc];
        end else begin
          hold_next  = hold_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      word_reg  <= 4'd0;
      index_reg <= 2'd0;
      hold_reg  <= 8'd0;
      sel_reg   <= 2'd0;
      i_reg     <= 1'b0;
      e_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      index_reg <= index_next;
      hold_reg  <= hold_next;
      sel_reg   <= sel_next;
      i_reg     <= i_next;
      e_reg     <= e_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
    end
  end

  assign in_ready = ready_reg;
  assign s0       = sel_reg[0];
  assign s1       = sel_reg[1];
  assign i        = i_reg;
  assign e        = e_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_scan_ctrl
//   Drives two instances (HOLD_CYCLES = 1 and 3) with shared stimulus and
//   compares all outputs every cycle against a transfer-level model: a
//   transfer is "active" for 4*H cycles counted by a position, and the
//   select index is simply position / H.
// -----------------------------------------------------------------------------
module tb_demux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       abort;

  logic rdy_a, s0_a, s1_a, i_a, e_a, busy_a, done_a;
  logic rdy_b, s0_b, s1_b, i_b, e_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.HOLD_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef DEMUX_SCAN_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_ready(rdy_a), .s0(s0_a), .s1(s1_a), .i(i_a), .e(e_a),
    .busy(busy_a), .done(done_a)
  );

  demux_scan_ctrl #(.HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef DEMUX_SCAN_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_ready(rdy_b), .s0(s0_b), .s1(s1_b), .i(i_b), .e(e_b),
    .busy(busy_b), .done(done_b)
  );

  // Reference model state, one entry per instance.
  int         hold_of [2] = '{1, 3};
  bit         m_active[2];
  int         m_pos   [2];
  logic [3:0] m_word  [2];
  bit         m_done  [2];

  // Expected {in_ready, s1, s0, i, e, busy, done}.
  function automatic logic [6:0] exp_vec(int k);
    logic [1:0] idx;
    if (m_active[k]) begin
      idx = 2'(m_pos[k] / hold_of[k]);
      return {1'b0, idx, m_word[k][idx], 1'b1, 1'b1, m_done[k]};
    end
    return {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, m_done[k]};
  endfunction

  task automatic model_edge(int k, logic r, logic v, logic [3:0] d, logic a);
    bit ab;
`ifdef DEMUX_SCAN_CTRL_ABORT_EN
    ab = a;
`else
    ab = 1'b0;
    if (a) ab = 1'b0;
`endif
    if (r) begin
      m_active[k] = 0;
      m_done[k]   = 0;
    end else if (m_active[k]) begin
      m_done[k] = 0;
      if (ab) begin
        m_active[k] = 0;
      end else if (m_pos[k] == 4 * hold_of[k] - 1) begin
        m_active[k] = 0;
        m_done[k]   = 1;
      end else begin
        m_pos[k]++;
      end
    end else begin
      m_done[k] = 0;
      if (v) begin
        m_active[k] = 1;
        m_pos[k]    = 0;
        m_word[k]   = d;
        $display("[TB] cycle %0d H=%0d accept word=%h", cycle, hold_of[k], d);
      end
    end
  endtask

  task automatic check(string tag, logic [6:0] got, logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b (rdy,s1,s0,i,e,busy,done)", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock edge, advance the model, then compare at the
  // following falling edge.
  task automatic step(logic r, logic v, logic [3:0] d, logic a);
    rst      = r;
    in_valid = v;
    in_data  = d;
    abort    = a;
    @(posedge clk);
    cycle++;
    for (int k = 0; k < 2; k++) model_edge(k, r, v, d, a);
    @(negedge clk);
    check($sformatf("h1_c%0d", cycle), {rdy_a, s1_a, s0_a, i_a, e_a, busy_a, done_a}, exp_vec(0));
    check($sformatf("h3_c%0d", cycle), {rdy_b, s1_b, s0_b, i_b, e_b, busy_b, done_b}, exp_vec(1));
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_pos[k] = 0; m_word[k] = 4'h0; m_done[k] = 0;
    end
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; abort = 1'b0;

    // Reset, with in_valid high to show it is ignored during reset.
    step(1'b1, 1'b1, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);

    // All-ones word, single-cycle valid.
    step(1'b0, 1'b1, 4'hF, 1'b0);
    idle(14);

    // Alternating word.
    step(1'b0, 1'b1, 4'h5, 1'b0);
    idle(14);

    // Valid held continuously: A then 3, accepted in the done cycle.
    step(1'b0, 1'b1, 4'hA, 1'b0);
    for (int c = 0; c < 16; c++) step(1'b0, 1'b1, 4'h3, 1'b0);
    idle(14);

    // Zero word, valid pulsed with F during the transfer.
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 1'b0);
    idle(14);

    // Reset mid-transfer (index 2 for H=1), then a fresh word.
    step(1'b0, 1'b1, 4'hB, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h6, 1'b0);
    idle(14);

`ifdef DEMUX_SCAN_CTRL_ABORT_EN
    // Abort at index 1 (H=1), abort in IDLE together with valid.
    step(1'b0, 1'b1, 4'hF, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    idle(14);
    step(1'b0, 1'b1, 4'h9, 1'b1);
    idle(14);
`endif

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      logic r, v, a;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 2) != 0);
`ifdef DEMUX_SCAN_CTRL_ABORT_EN
      a = ($urandom_range(0, 24) == 0);
`else
      a = 1'b0;
`endif
      step(r, v, 4'($urandom_range(0, 15)), a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
